// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N-channel registered display mux, manual select or auto scan with a blank gap per advance; in clk rst mode sel blank ent, out out en cur_sel tick
module mux_nx1_scan #(
  parameter int P_WIDTH = 7,
  parameter int P_CHANNELS = 4,
  parameter int P_DIV = 50000,
  parameter logic [P_WIDTH-1:0] P_BLANK_VAL = P_WIDTH'(7'h7F),
  localparam int SEL_W = $clog2(P_CHANNELS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          blank,
  input  logic [P_CHANNELS*P_WIDTH-1:0] ent,
  output logic [P_WIDTH-1:0]            out,
  output logic [P_CHANNELS-1:0]         en,
  output logic [SEL_W-1:0]              cur_sel,
  output logic                          tick
);
  localparam int PW = $clog2(P_DIV);
  logic [PW-1:0] psc_q, psc_d;
  logic [SEL_W-1:0] sel_q, sel_d, pick;
  logic [P_WIDTH-1:0] out_q, out_d;
  logic [P_CHANNELS-1:0] en_q, en_d;
  logic tick_q, tick_d, adv;
  always_comb begin
    adv = mode && psc_q == PW'(P_DIV - 1);
    pick = mode ? sel_q : (int'(sel) < P_CHANNELS ? sel : '0);
    psc_d = mode && !adv ? psc_q + PW'(1) : '0;
    sel_d = adv ? (sel_q == SEL_W'(P_CHANNELS - 1) ? '0 : sel_q + SEL_W'(1)) : pick;
    tick_d = adv;
    out_d = blank || adv ? P_BLANK_VAL : ent[int'(pick)*P_WIDTH +: P_WIDTH];
    en_d = blank || adv ? '0 : P_CHANNELS'(1) << pick;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q  <= '0;
      sel_q  <= '0;
      out_q  <= P_BLANK_VAL;
      en_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      sel_q  <= sel_d;
      out_q  <= out_d;
      en_q   <= en_d;
      tick_q <= tick_d;
    end
  end
  assign out = out_q;
  assign en = en_q;
  assign cur_sel = sel_q;
  assign tick = tick_q;
endmodule
